lab_mode_mux: RTL and testbench
===============================

LAB_MODE_MUX -- requirements
Module: lab_mode_mux

Interface
REQ-001 SHALL have parameter NCH, default 4: number of design channels sharing the board I/O, 2..8.
REQ-002 SHALL have parameter NHEX, default 6: number of 7-segment digits, 8 bits each, active-low.
REQ-003 SHALL have parameter NLED, default 8: number of muxed LEDR bits.
REQ-004 SHALL have parameter DEB_CYCLES, default 500000: debounce stability window in clocks.
REQ-005 SHALL have parameter BLANK_CYCLES, default 5000000: blanking interval after a channel change.
REQ-006 SHALL have parameter SCAN_CYCLES, default 100000000: auto-scan dwell per channel.
REQ-007 SHALL have port MAX10_CLK1_50, input, 1 bit: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port sel_sw, input, CW=$clog2(NCH) bits: manual channel select.
REQ-010 SHALL have port step_n, input, 1 bit: raw KEY, active-low, asynchronous to the clock.
REQ-011 SHALL have port auto_en, input, 1 bit: 1 = step/scan mode, 0 = manual mode.
REQ-012 SHALL have port hex_in, input, NCH*NHEX*8 bits: channel c occupies bits [c*NHEX*8 +: NHEX*8].
REQ-013 SHALL have port led_in, input, NCH*NLED bits: channel c occupies bits [c*NLED +: NLED].
REQ-014 SHALL have port HEX, output, NHEX*8 bits: registered digit outputs.
REQ-015 SHALL have port LEDR, output, NLED bits: registered LED outputs.
REQ-016 SHALL have port ch, output, CW bits: currently displayed channel.
REQ-017 SHALL have port blanking, output, 1 bit: high while in BLANK.

Function
REQ-018 SHALL pass step_n through a 2-FF synchroniser before any use.
REQ-019 SHALL register a debounced level change only after the synchronised input has held a new value for DEB_CYCLES consecutive clocks; each debounced high-to-low transition SHALL produce exactly one one-cycle press pulse.
REQ-020 SHALL, in manual mode, form target = sel_sw, clamped to NCH-1 when sel_sw >= NCH.
REQ-021 SHALL, in auto mode, advance target by 1 on a press pulse or a scan timeout, wrapping NCH-1 -> 0; a coincident press and timeout SHALL produce one advance.
REQ-022 SHALL restart the scan timer on every advance, on every mode change and on reset; timeout occurs when SCAN_CYCLES clocks elapse with no advance.
REQ-023 SHALL, on a 0 -> 1 transition of auto_en, load target from ch so the display does not jump.
REQ-024 SHALL implement the FSM BLANK -> SHOW, leaving BLANK after BLANK_CYCLES clocks.
REQ-025 SHALL, in SHOW, enter BLANK with ch <= target on the next edge when target != ch.
REQ-026 SHALL, when target changes while in BLANK, update ch and restart the full BLANK_CYCLES count.
REQ-027 SHALL drive HEX all ones and LEDR all zeros in BLANK, and blanking=1.
REQ-028 SHALL, in SHOW, register HEX = hex_in slice[ch] and LEDR = led_in slice[ch] with 1-clock latency; blanking=0.

Reset
REQ-029 SHALL, while rst=1: HEX all ones, LEDR 0, ch 0, target 0, blanking 1, FSM BLANK, all counters 0, debounced level high.
REQ-030 SHALL, after rst deasserts, complete BLANK_CYCLES of BLANK before the first SHOW; assertion mid-blank or mid-scan SHALL abort the interval immediately.

Configuration
REQ-031 SHALL support macro LAB_AUTO_SCAN_EN: when defined, the scan timer and REQ-021 timeout exist; when undefined, no scan timer is built and auto mode advances on press pulses only; SCAN_CYCLES is then ignored.

Verification (NCH=3, NHEX=6, NLED=8, DEB_CYCLES=3, BLANK_CYCLES=4, SCAN_CYCLES=16, macro defined)
REQ-032 Reset release, sel_sw=0, auto_en=0, hex_in ch0=48'h0123456789AB -> blanking for 4 clocks, then HEX=48'h0123456789AB one clock later, ch=0.
REQ-033 Manual sel_sw=3 -> ch=2 (clamped); sel_sw changed 2->1 during blank -> ch=1, blank restarts at 4.
REQ-034 auto_en=1 with step_n idle -> ch sequence 0,1,2,0 at 16-clock dwell; each advance is followed by 4 blanked clocks.
REQ-035 step_n low 2 clocks then high -> no advance; low 10 clocks with bounce in the first 2 -> exactly one advance.
REQ-036 Press pulse on the same clock as timeout -> single advance, timer restarts; rst mid-blank -> outputs at reset values within the same cycle.

Source files
------------

// File: rtl/lab_mode_mux.sv
// Board I/O sharer: picks one of NCH design channels for HEX/LEDR, blanking on every switch.
// Define LAB_AUTO_SCAN_EN to build the auto-scan timer; without it auto mode only steps on key presses.
module lab_mode_mux #(
    parameter int NCH          = 4,
    parameter int NHEX         = 6,
    parameter int NLED         = 8,
    parameter int DEB_CYCLES   = 500000,
    parameter int BLANK_CYCLES = 5000000,
    parameter int SCAN_CYCLES  = 100000000
) (
    input  logic                      MAX10_CLK1_50,
    input  logic                      rst,
    input  logic [$clog2(NCH)-1:0]    sel_sw,
    input  logic                      step_n,
    input  logic                      auto_en,
    input  logic [NCH*NHEX*8-1:0]     hex_in,
    input  logic [NCH*NLED-1:0]       led_in,
    output logic [NHEX*8-1:0]         HEX,
    output logic [NLED-1:0]           LEDR,
    output logic [$clog2(NCH)-1:0]    ch,
    output logic                      blanking
);

    localparam int CW = $clog2(NCH);
    localparam int HW = NHEX * 8;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    function automatic logic [CW-1:0] clamp_sel(input logic [CW-1:0] s);
        if ({1'b0, s} >= (CW+1)'(NCH))
            return CW'(NCH - 1);
        return s;
    endfunction

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return (v == CW'(NCH - 1)) ? '0 : v + CW'(1);
    endfunction

    logic          step_p0, step_p1;
    logic          deb_lvl;
    logic [DW-1:0] deb_cnt;
    logic          deb_hit, press;
    logic          auto_q, mode_chg, timeout, advance;
    logic [CW-1:0] target;
    state_t        state, state_nxt;
    logic [CW-1:0] ch_nxt;
    logic [BW-1:0] blank_cnt, blank_cnt_nxt;
    logic [HW-1:0]   hex_sel;
    logic [NLED-1:0] led_sel;

    // stage p0/p1: two-flop synchroniser for the raw key
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            step_p0 <= 1'b1;
            step_p1 <= 1'b1;
        end else begin
            step_p0 <= step_n;
            step_p1 <= step_p0;
        end
    end

    // debounced level flips only after DEB_CYCLES consecutive disagreeing samples
    assign deb_hit = (step_p1 != deb_lvl) && (deb_cnt == DW'(DEB_CYCLES - 1));
    assign press   = deb_hit && !step_p1;

    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            deb_lvl <= 1'b1;
            deb_cnt <= '0;
        end else if (step_p1 == deb_lvl) begin
            deb_cnt <= '0;
        end else if (deb_hit) begin
            deb_lvl <= step_p1;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    assign mode_chg = (auto_en != auto_q);
    assign advance  = auto_en && !mode_chg && (press || timeout);

`ifdef LAB_AUTO_SCAN_EN
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    logic [SW-1:0] scan_cnt;

    assign timeout = auto_en && (scan_cnt == SW'(SCAN_CYCLES - 1));

    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst)
            scan_cnt <= '0;
        else if (!auto_en || mode_chg || advance)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + SW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // entering auto mode adopts the shown channel so the display does not jump
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            auto_q <= 1'b0;
            target <= '0;
        end else begin
            auto_q <= auto_en;
            if (!auto_en)
                target <= clamp_sel(sel_sw);
            else if (mode_chg)
                target <= ch;
            else if (advance)
                target <= wrap_inc(target);
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            state     <= ST_BLANK;
            ch        <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            blank_cnt <= blank_cnt_nxt;
        end
    end

    // any target change, in either state, restarts a full blanking interval
    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        blank_cnt_nxt = blank_cnt;
        case (state)
            ST_BLANK: begin
                if (target != ch) begin
                    ch_nxt        = target;
                    blank_cnt_nxt = '0;
                end else if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
                    state_nxt     = ST_SHOW;
                    blank_cnt_nxt = '0;
                end else begin
                    blank_cnt_nxt = blank_cnt + BW'(1);
                end
            end
            ST_SHOW: begin
                if (target != ch) begin
                    state_nxt     = ST_BLANK;
                    ch_nxt        = target;
                    blank_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    always_comb begin
        hex_sel = '1;
        led_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch == CW'(c)) begin
                hex_sel = hex_in[c*HW +: HW];
                led_sel = led_in[c*NLED +: NLED];
            end
        end
    end

    // stage out: data only while staying in SHOW, so the first SHOW clock is still blank
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            HEX  <= '1;
            LEDR <= '0;
        end else if (state == ST_SHOW && state_nxt == ST_SHOW) begin
            HEX  <= hex_sel;
            LEDR <= led_sel;
        end else begin
            HEX  <= '1;
            LEDR <= '0;
        end
    end

    assign blanking = (state == ST_BLANK);

endmodule

// File: tb/tb_lab_mode_mux.sv
// Bench for lab_mode_mux: directed scenarios plus randomized traffic against an edge-timestamp model.
module tb_lab_mode_mux;

    localparam int NCH  = 3;
    localparam int NHEX = 6;
    localparam int NLED = 8;
    localparam int DEB  = 3;
    localparam int BLK  = 4;
    localparam int SCAN = 16;
    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   sel_sw;
    logic         step_n;
    logic         auto_en;
    logic [143:0] hex_in;
    logic [23:0]  led_in;
    logic [47:0]  HEX;
    logic [7:0]   LEDR;
    logic [1:0]   ch;
    logic         blanking;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    lab_mode_mux #(
        .NCH(NCH), .NHEX(NHEX), .NLED(NLED),
        .DEB_CYCLES(DEB), .BLANK_CYCLES(BLK), .SCAN_CYCLES(SCAN)
    ) dut (
        .MAX10_CLK1_50(clk),
        .rst(rst),
        .sel_sw(sel_sw),
        .step_n(step_n),
        .auto_en(auto_en),
        .hex_in(hex_in),
        .led_in(led_in),
        .HEX(HEX),
        .LEDR(LEDR),
        .ch(ch),
        .blanking(blanking)
    );

    // reference model: timestamps of the last blank start / scan restart, raw key history
    int          m_e, m_tgt, m_ch, m_bs, m_ss;
    bit          m_lvl, m_aq, m_show;
    logic [47:0] m_hex;
    logic [7:0]  m_led;
    bit          rawq[$];

    function automatic bit raw_at(int k);
        if (k < 1) return 1'b1;
        return rawq[k-1];
    endfunction

    task automatic model_reset();
        m_e = 0; m_tgt = 0; m_ch = 0; m_bs = 0; m_ss = 0;
        m_lvl = 1'b1; m_aq = 1'b0; m_show = 1'b0;
        m_hex = ONES; m_led = '0;
        rawq.delete();
    endtask

    task automatic model_edge();
        int e, man, ntgt, nch;
        bit flip, press, tmo, adv, mchg, nshow;
        if (rst) begin
            model_reset();
            return;
        end
        m_e++;
        rawq.push_back(step_n);
        e = m_e;
        // the synchronised sample seen at edge e is the raw key from edge e-2
        flip = 1'b1;
        for (int j = 0; j < DEB; j++)
            if (raw_at(e - 2 - j) == m_lvl) flip = 1'b0;
        press = flip && m_lvl;
        mchg  = (auto_en != m_aq);
        tmo   = 1'b0;
`ifdef LAB_AUTO_SCAN_EN
        tmo = auto_en && !mchg && (e - m_ss == SCAN);
`endif
        adv  = auto_en && !mchg && (press || tmo);
        man  = (int'(sel_sw) >= NCH) ? NCH - 1 : int'(sel_sw);
        if (!auto_en)   ntgt = man;
        else if (mchg)  ntgt = m_ch;
        else if (adv)   ntgt = (m_tgt + 1) % NCH;
        else            ntgt = m_tgt;
        nch = m_ch;
        nshow = m_show;
        if (m_tgt != m_ch) begin
            nch = m_tgt;
            nshow = 1'b0;
            m_bs = e;
        end else if (!m_show && (e - m_bs == BLK)) begin
            nshow = 1'b1;
        end
        if (m_show && nshow) begin
            m_hex = hex_in[m_ch*48 +: 48];
            m_led = led_in[m_ch*8 +: 8];
        end else begin
            m_hex = ONES;
            m_led = '0;
        end
        if (flip) m_lvl = !m_lvl;
        if (!auto_en || mchg || adv) m_ss = e;
        m_aq = auto_en;
        m_tgt = ntgt;
        m_ch = nch;
        m_show = nshow;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("HEX", 64'(HEX), 64'(m_hex));
        chk("LEDR", 64'(LEDR), 64'(m_led));
        chk("ch", 64'(ch), 64'(m_ch));
        chk("blanking", 64'(blanking), 64'(!m_show));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_HEX", 64'(HEX), 64'(ONES));
        chk("rst_LEDR", 64'(LEDR), 64'(0));
        chk("rst_ch", 64'(ch), 64'(0));
        chk("rst_blanking", 64'(blanking), 64'(1));
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r;
        int hold;
        rst = 1'b1; step_n = 1'b1; auto_en = 1'b0; sel_sw = 2'd0;
        for (int c = 0; c < NCH; c++) begin
            r = {$urandom(), $urandom()};
            hex_in[c*48 +: 48] = r[47:0];
        end
        hex_in[47:0] = 48'h0123456789AB;
        r = {$urandom(), $urandom()};
        led_in = r[23:0];
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // reset release: four blanked clocks, then channel 0 data one clock later
        repeat (3) tick();
        chk("r032_blank3", 64'(blanking), 64'(1));
        tick();
        chk("r032_show", 64'(blanking), 64'(0));
        chk("r032_hex_lat", 64'(HEX), 64'(ONES));
        tick();
        chk("r032_hex", 64'(HEX), 64'(48'h0123456789AB));
        chk("r032_ch", 64'(ch), 64'(0));

        // manual clamp and retarget during blank
        sel_sw = 2'd3;
        tick(); tick();
        chk("r033_clamp", 64'(ch), 64'(2));
        chk("r033_clamp_blank", 64'(blanking), 64'(1));
        repeat (4) tick();
        sel_sw = 2'd0;
        tick(); tick(); tick();
        sel_sw = 2'd2;
        tick(); tick(); tick();
        sel_sw = 2'd1;
        tick(); tick();
        chk("r033_ch1", 64'(ch), 64'(1));
        repeat (3) tick();
        chk("r033_restart_blank", 64'(blanking), 64'(1));
        tick();
        chk("r033_restart_show", 64'(blanking), 64'(0));

        // auto scan 0,1,2,0 at 16-clock dwell
        sel_sw = 2'd0;
        repeat (8) tick();
        auto_en = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
`ifdef LAB_AUTO_SCAN_EN
            if (i == 17) chk("r034_dwell0", 64'(ch), 64'(0));
            if (i == 18) chk("r034_ch1", 64'(ch), 64'(1));
            if (i == 21) chk("r034_blank_hold", 64'(blanking), 64'(1));
            if (i == 22) chk("r034_blank_end", 64'(blanking), 64'(0));
            if (i == 33) chk("r034_dwell1", 64'(ch), 64'(1));
            if (i == 34) chk("r034_ch2", 64'(ch), 64'(2));
            if (i == 50) chk("r034_wrap", 64'(ch), 64'(0));
`endif
        end

        // short press ignored, bouncy long press gives one advance
        auto_en = 1'b0;
        tick();
        auto_en = 1'b1;
        tick();
        step_n = 1'b0;
        tick(); tick();
        step_n = 1'b1;
        repeat (6) tick();
        chk("r035_short", 64'(ch), 64'(0));
        step_n = 1'b0;
        tick();
        step_n = 1'b1;
        tick();
        step_n = 1'b0;
        repeat (8) tick();
        step_n = 1'b1;
        repeat (4) tick();
        chk("r035_long", 64'(ch), 64'(1));

`ifdef LAB_AUTO_SCAN_EN
        // press lands on the timeout edge: one advance, timer restarts there
        for (int k = 0; k < 40 && (m_e - m_ss) != SCAN - 5; k++) tick();
        step_n = 1'b0;
        repeat (5) tick();
        chk("r036_pre", 64'(ch), 64'(1));
        tick();
        chk("r036_single", 64'(ch), 64'(2));
        step_n = 1'b1;
        repeat (15) tick();
        chk("r036_restart_hold", 64'(ch), 64'(2));
        tick();
        chk("r036_restart_adv", 64'(ch), 64'(0));
        tick();
`endif
        // reset in the middle of a blank
        apply_reset();

        // randomized traffic with one mid-run reset
        auto_en = 1'b1;
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) sel_sw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) auto_en = !auto_en;
            if (hold == 0) begin
                step_n = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) begin
                r = {$urandom(), $urandom()};
                hex_in[$urandom_range(0, NCH-1)*48 +: 48] = r[47:0];
                led_in = r[55:32];
            end
            if (n == 300) apply_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
